// File: rtl/npc_lsu.sv
// rtl/npc_lsu.sv - single-outstanding load/store unit with byte-lane alignment and load extension
// Define NPC_LSU_MISALIGN_CHK_EN to trap misaligned accesses instead of aligning them down.
module npc_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic [4:0]        rsp_rd_o,
  output logic              rsp_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wmask_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o
);
  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              rdy_q;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]        rd_q, rd_d;

  logic              accept, req_err, sign;
  logic [OFS_W-1:0]  ofs;
  logic [XLEN-1:0]   shifted, ld_data;

  function automatic logic [OFS_W-1:0] low_mask(input logic [1:0] size);
    return OFS_W'((32'd1 << size) - 32'd1);
  endfunction

`ifdef NPC_LSU_MISALIGN_CHK_EN
  logic [OFS_W-1:0] req_ofs;
  assign req_ofs = req_addr_i[OFS_W-1:0];
`endif

  // A double-word request on a 32-bit datapath is always illegal, with or without the checker.
  always_comb begin
    req_err = (XLEN == 32) && (req_size_i == 2'd3);
`ifdef NPC_LSU_MISALIGN_CHK_EN
    if (((req_ofs & low_mask(req_size_i)) != '0) ||
        ((int'(req_ofs) + (1 << req_size_i)) > NB)) begin
      req_err = 1'b1;
    end
`endif
  end

  assign req_ready_o = rdy_q && (state_q == S_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = (state_q != S_IDLE);

  // Lane offset is aligned down to the access size; trapped accesses never reach memory anyway.
  assign ofs = addr_q[OFS_W-1:0] & ~low_mask(size_q);

  always_comb begin
    shifted = mem_rdata_i >> {ofs, 3'b000};
    case (size_q)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    sign = sign & ~uns_q;
    ld_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_data[i] = (i < (8 << size_q)) ? shifted[i] : sign;
    end
  end

  always_comb begin
    mem_wmask_o = '0;
    for (int i = 0; i < NB; i++) begin
      mem_wmask_o[i] = we_q && (i >= int'(ofs)) && (i < int'(ofs) + (1 << size_q));
    end
  end

  assign mem_valid_o = (state_q == S_CMD);
  assign mem_we_o    = (state_q == S_CMD) && we_q;
  assign mem_addr_o  = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign mem_wdata_o = wdata_q << {ofs, 3'b000};

  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
  assign rsp_rd_o    = (state_q == S_RESP) ? rd_q : 5'd0;
  assign rsp_err_o   = (state_q == S_RESP) && err_q;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rd_d    = req_rd_i;
          err_d   = req_err;
          rdata_d = '0;
          state_d = req_err ? S_RESP : S_CMD;
        end
      end
      S_CMD: begin
        if (mem_ready_i) state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// tb/tb_npc_lsu.sv - randomized and directed bench for npc_lsu against a byte-arithmetic model
module tb_npc_lsu;
`ifdef NPC_LSU_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd, rsp_rd;
  logic        rsp_valid, rsp_err, mem_valid, mem_ready, mem_we, mem_rvalid, busy;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        w_valid, w_ready, w_we, w_uns, w_rsp_valid, w_rsp_err;
  logic        w_mvalid, w_mready, w_mwe, w_rvalid, w_busy;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_maddr;
  logic [63:0] w_wdata, w_rsp_rdata, w_mwdata, w_rdata;
  logic [4:0]  w_rd, w_rsp_rd;
  logic [7:0]  w_mwmask;

  npc_lsu #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_rd_o(rsp_rd), .rsp_err_o(rsp_err),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  npc_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(w_valid), .req_ready_o(w_ready), .req_we_i(w_we),
    .req_size_i(w_size), .req_unsigned_i(w_uns), .req_addr_i(w_addr),
    .req_wdata_i(w_wdata), .req_rd_i(w_rd),
    .rsp_valid_o(w_rsp_valid), .rsp_rdata_o(w_rsp_rdata), .rsp_rd_o(w_rsp_rd), .rsp_err_o(w_rsp_err),
    .mem_valid_o(w_mvalid), .mem_ready_i(w_mready), .mem_we_o(w_mwe), .mem_addr_o(w_maddr),
    .mem_wdata_o(w_mwdata), .mem_wmask_o(w_mwmask), .mem_rvalid_i(w_rvalid),
    .mem_rdata_i(w_rdata), .busy_o(w_busy)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_mask;
  logic        last_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference load: pick the bytes out arithmetically, then fold into a signed value if needed.
  function automatic logic [31:0] m_load(input logic [31:0] beat, input int ofs, input int bytes,
                                         input logic uns);
    longint unsigned v, lim;
    v   = 64'(beat) >> (8 * ofs);
    lim = 64'd1 << (8 * bytes);
    v   = v % lim;
    if (!uns && v >= (lim >> 1)) v = v - lim;
    return v[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " mem_valid"}, 64'(mem_valid), 64'(0));
    chk({tag, " mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, " mem_wmask"}, 64'(mem_wmask), 64'(0));
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, " rsp_rd"}, 64'(rsp_rd), 64'(0));
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(0));
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_dly, input int rv_dly, input logic [31:0] beat,
                        input bit poke);
    int bytes, raw, ofs;
    bit exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_mask;
    logic [4:0]  tag;
    longint unsigned t;
    bytes     = 1 << size;
    raw       = int'(addr[1:0]);
    ofs       = (raw / bytes) * bytes;
    exp_err   = (size == 2'd3) || (CHK && (raw % bytes) != 0);
    exp_addr  = addr - 32'(raw);
    t         = 64'(wdata) << (8 * ofs);
    exp_wdata = t[31:0];
    exp_mask  = we ? 4'(((1 << bytes) - 1) << ofs) : 4'h0;
    exp_rdata = (we || exp_err) ? 32'h0 : m_load(beat, ofs, bytes, uns);
    tag       = 5'($urandom);

    chk("req_ready before", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = tag;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    if (exp_err) begin
      chk("no mem cmd on error", 64'(mem_valid), 64'(0));
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        chk("mem_valid", 64'(mem_valid), 64'(1));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        chk("mem_we", 64'(mem_we), 64'(we));
        chk("mem_wmask", 64'(mem_wmask), 64'(exp_mask));
        if (we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        chk("busy in cmd", 64'(busy), 64'(1));
        if (poke) begin
          req_valid = 1'b1;
          chk("req_ready while busy", 64'(req_ready), 64'(0));
        end
        last_addr = mem_addr; last_mask = mem_wmask; last_wdata = mem_wdata;
        mem_ready  = (k == rdy_dly);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        @(negedge clk);
      end
      req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (!we) begin
        for (int k = 0; k <= rv_dly; k++) begin
          chk("rsp_valid early", 64'(rsp_valid), 64'(0));
          mem_rvalid = (k == rv_dly);
          mem_rdata  = (k == rv_dly) ? beat : $urandom;
          mem_ready  = 1'($urandom);
          @(negedge clk);
        end
        mem_rvalid = 1'b0; mem_ready = 1'b0;
      end
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_rd", 64'(rsp_rd), 64'(tag));
    last_rdata = rsp_rdata; last_err = rsp_err;
    @(negedge clk);
    chk("rsp single pulse", 64'(rsp_valid), 64'(0));
    chk("req_ready after", 64'(req_ready), 64'(1));
  endtask

  task automatic access64(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] beat,
                          input logic [31:0] e_addr, input logic [7:0] e_mask,
                          input logic [63:0] e_wdata, input logic [63:0] e_rdata);
    w_valid = 1'b1; w_we = we; w_size = size; w_uns = uns; w_addr = addr; w_wdata = wdata;
    w_rd = 5'd7;
    @(negedge clk);
    w_valid = 1'b0;
    chk("x64 mem_valid", 64'(w_mvalid), 64'(1));
    chk("x64 mem_addr", 64'(w_maddr), 64'(e_addr));
    chk("x64 mem_wmask", 64'(w_mwmask), 64'(e_mask));
    if (we) chk("x64 mem_wdata", w_mwdata, e_wdata);
    w_mready = 1'b1;
    @(negedge clk);
    w_mready = 1'b0;
    if (!we) begin
      chk("x64 rsp_valid early", 64'(w_rsp_valid), 64'(0));
      w_rvalid = 1'b1; w_rdata = beat;
      @(negedge clk);
      w_rvalid = 1'b0; w_rdata = 64'h0;
    end
    chk("x64 rsp_valid", 64'(w_rsp_valid), 64'(1));
    chk("x64 rsp_err", 64'(w_rsp_err), 64'(0));
    chk("x64 rsp_rdata", w_rsp_rdata, e_rdata);
    chk("x64 rsp_rd", 64'(w_rsp_rd), 64'(7));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    req_rd = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    w_valid = 0; w_we = 0; w_size = 0; w_uns = 0; w_addr = 0; w_wdata = 0; w_rd = 0;
    w_mready = 0; w_rvalid = 0; w_rdata = 0;
    last_addr = 0; last_wdata = 0; last_rdata = 0; last_mask = 0; last_err = 0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    chk("reset x64 req_ready", 64'(w_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after release", 64'(req_ready), 64'(1));

    access(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB, 0, 0, 32'h0, 1'b0);
    chk("sb addr", 64'(last_addr), 64'(32'h8000_0000));
    chk("sb mask", 64'(last_mask), 64'(4'b1000));
    chk("sb wdata", 64'(last_wdata), 64'(32'hAB00_0000));

    access(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 32'h8001_0000, 1'b0);
    chk("lh signed", 64'(last_rdata), 64'(32'hFFFF_8001));
    access(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 0, 0, 32'h8001_0000, 1'b0);
    chk("lhu", 64'(last_rdata), 64'(32'h0000_8001));

    access(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'h1234_5678, 5, 0, 32'h0, 1'b1);
    access(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 5, 4, 32'hCAFE_F00D, 1'b1);

    access(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0);
`ifdef NPC_LSU_MISALIGN_CHK_EN
    chk("lw misaligned err", 64'(last_err), 64'(1));
    chk("lw misaligned rdata", 64'(last_rdata), 64'(0));
`else
    chk("lw misaligned addr", 64'(last_addr), 64'(32'h8000_0000));
    access(1'b1, 2'd2, 1'b0, 32'h8000_0002, 32'hA5A5_5A5A, 0, 0, 32'h0, 1'b0);
    chk("sw misaligned mask", 64'(last_mask), 64'(4'b1111));
`endif

    access(1'b0, 2'd3, 1'b0, 32'h8000_0008, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0);
    chk("size3 on 32-bit err", 64'(last_err), 64'(1));

    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("wait busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stale rvalid no rsp", 64'(rsp_valid), 64'(0));
      chk("stale rvalid idle", 64'(busy), 64'(0));
    end
    mem_rvalid = 1'b0;
    chk("ready after abort", 64'(req_ready), 64'(1));

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      access(1'($urandom), sz, 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
    end

    access64(1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'h0, 64'hFEDC_BA98_7654_3210,
             32'h8000_0008, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210);
    access64(1'b0, 2'd0, 1'b0, 32'h8000_0005, 64'h0, 64'hFEDC_BA98_7654_3210,
             32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFBA);
    access64(1'b0, 2'd2, 1'b1, 32'h8000_0004, 64'h0, 64'hFEDC_BA98_7654_3210,
             32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_FEDC_BA98);
    access64(1'b1, 2'd3, 1'b0, 32'h8000_0010, 64'h1122_3344_5566_7788, 64'h0,
             32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
    access64(1'b1, 2'd1, 1'b0, 32'h8000_0016, 64'h0000_0000_0000_BEEF, 64'h0,
             32'h8000_0010, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/npc_lsu.md
NPC_LSU -- requirements
Module: npc_lsu

Interface
REQ-001 Parameter: XLEN, 32, data width; legal values are 32 and 64.
REQ-002 Parameter: ADDR_W, 32, address width.
REQ-003 Derived: NB = XLEN/8 bytes per beat; OFS_W = log2(NB).
REQ-004 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: req_valid  in  1  core access request.
REQ-007 Port: req_ready  out  1  unit idle, request accepted when both are high.
REQ-008 Port: req_we  in  1  1 = store, 0 = load.
REQ-009 Port: req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-010 Port: req_unsigned  in  1  zero-extend load result.
REQ-011 Port: req_addr  in  ADDR_W  byte address.
REQ-012 Port: req_wdata  in  XLEN  store data, right-aligned.
REQ-013 Port: req_rd  in  5  destination register tag, returned unchanged.
REQ-014 Port: rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-015 Port: rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-016 Port: rsp_rd  out  5  tag of the completing access.
REQ-017 Port: rsp_err  out  1  access failed (misaligned or illegal size).
REQ-018 Port: mem_valid / mem_ready  out / in  1 / 1  memory command handshake.
REQ-019 Port: mem_we  out  1  memory write enable.
REQ-020 Port: mem_addr  out  ADDR_W  address with the low OFS_W bits forced to 0.
REQ-021 Port: mem_wdata  out  XLEN  lane-shifted store data.
REQ-022 Port: mem_wmask  out  NB  byte-lane write mask; all 0 on loads.
REQ-023 Port: mem_rvalid / mem_rdata  in / in  1 / XLEN  read return, full beat.
REQ-024 Port: busy  out  1  high whenever the state is not IDLE.

Function
REQ-025 FSM states are IDLE, CMD, WAIT, and RESP; req_ready = (state == IDLE).
REQ-026 IDLE: on req_valid, the unit latches all req_* fields and moves to CMD, unless the access is erroneous (REQ-031), in which case it moves to RESP.
REQ-027 CMD: mem_valid is held high with stable outputs until mem_ready; then a store moves to RESP and a load moves to WAIT.
REQ-028 WAIT: the unit waits for mem_rvalid, which is sampled no earlier than the cycle after the CMD handshake; it then captures mem_rdata and moves to RESP.
REQ-029 RESP: rsp_valid is high for exactly one cycle, then the unit returns to IDLE. Minimum latency from accept to rsp_valid is 2 cycles for a store and 3 for a load.
REQ-030 Lane offset is ofs = addr[OFS_W-1:0]. Store: mem_wdata = req_wdata << (8*ofs); mem_wmask = ((1 << 2^size) - 1) << ofs.
REQ-031 req_size = 3 with XLEN = 32 is illegal: rsp_err = 1 and no memory access, independent of the macro.
REQ-032 Load: shift mem_rdata right by 8*ofs, truncate to 2^size bytes, then sign-extend (or zero-extend if req_unsigned) to XLEN. A double-word load on XLEN = 64 is returned unmodified.
REQ-033 mem_rvalid and mem_ready are ignored outside WAIT and CMD respectively.
REQ-034 Only one access is outstanding at a time; req_valid is ignored while busy.

Reset
REQ-035 While rst = 0: state = IDLE and every output is 0 (req_ready rises in the first cycle after release); all latched fields are cleared.
REQ-036 Reset asserted mid-access aborts the access with no rsp_valid. A mem_rvalid arriving after release, while in IDLE, is discarded.

Configuration
REQ-037 Macro NPC_LSU_MISALIGN_CHK_EN: when defined, an access with ofs not a multiple of 2^size, or one that crosses a beat, gives rsp_err = 1 via RESP with no memory access.
REQ-038 When NPC_LSU_MISALIGN_CHK_EN is undefined, the address is aligned down to 2^size before lane calculation and rsp_err arises only from REQ-031.

Verification
REQ-039 XLEN = 32. Store sb, addr 0x80000003, wdata 0xAB, mem_ready = 1 immediately -> mem_addr 0x80000000, mem_wmask 4'b1000, mem_wdata 0xAB000000, rsp_valid 2 cycles after accept.
REQ-040 Load lh, addr 0x80000002, mem_rdata 0x8001_0000, rvalid 1 cycle after handshake -> rsp_rdata 0xFFFF8001; with req_unsigned -> 0x00008001; rsp_valid at cycle 3.
REQ-041 mem_ready held low for 5 cycles -> mem_valid and mem_addr stay stable for all 5, busy = 1, a second req_valid is not accepted.
REQ-042 With the macro defined, lw at 0x80000002 -> rsp_err = 1, rsp_rdata = 0, mem_valid never asserted. With it undefined, the same access goes to 0x80000000 with mask 4'b1111.
REQ-043 Assert rst in WAIT, then present mem_rvalid after release -> no rsp_valid, outputs 0, req_ready = 1.
REQ-044 XLEN = 64. ld at 0x...08, rdata 0xFEDCBA9876543210 -> rsp_rdata identical. XLEN = 32 with size 3 -> rsp_err = 1.
